perf_stats_unit: RTL and testbench

//  Parametrised run-statistics unit; successor to the single-channel end-of-run stats printer.

---
 rtl/perf_stats_unit.sv | 188 ++++++++++++++++++
 tb/tb_perf_stats_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/perf_stats_unit.sv
// Run-statistics unit: counts cycles, retired instructions and generic events between start and
// stop, then computes fixed-point IPC with a restoring divider. Optional report: PERF_STATS_DISPLAY_EN.
module perf_stats_unit #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned RET_W   = 2,
  parameter int unsigned FRAC_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stat_control,
  input  logic [RET_W-1:0]         instr_inc,
  input  logic [NUM_EVT-1:0]       evt,
  output logic [CNT_W-1:0]         cycles,
  output logic [CNT_W-1:0]         instrs,
  output logic [NUM_EVT*CNT_W-1:0] evt_cnt,
  output logic [CNT_W-1:0]         ipc,
  output logic                     ipc_valid,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned Q_W  = CNT_W + FRAC_W;
  localparam int unsigned QC_W = $clog2(Q_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic               stat_prev_q;
  logic [CNT_W-1:0]   evt_q [NUM_EVT];
  logic [CNT_W-1:0]   evt_d [NUM_EVT];
  logic [CNT_W-1:0]   cyc_d, ins_d, ipc_d;
  logic               ipc_valid_d, busy_d, ovf_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [Q_W-1:0]     quo_q, quo_d;
  logic [QC_W-1:0]    bit_cnt_q, bit_cnt_d;

  logic               stop_edge;
  logic [CNT_W:0]     cyc_s, ins_s;
  logic [CNT_W:0]     evt_s [NUM_EVT];
  logic [CNT_W:0]     rem_sh;
  logic [CNT_W-1:0]   rem_sub;
  logic               q_bit;
  logic [Q_W-1:0]     quo_nxt;

  // Saturating add; MSB of the result flags that saturation occurred.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_W]) s = {1'b1, {CNT_W{1'b1}}};
    return s;
  endfunction

  always_comb begin
    cyc_s = sat_add(cycles, CNT_W'(1));
    ins_s = sat_add(instrs, CNT_W'(instr_inc));
    for (int i = 0; i < NUM_EVT; i++) begin
      evt_s[i] = sat_add(evt_q[i], CNT_W'(evt[i]));
    end
  end

  assign stop_edge = stat_control & ~stat_prev_q;

  // One restoring-division step; divisor is the frozen cycle count.
  assign rem_sh  = {rem_q, quo_q[Q_W-1]};
  assign q_bit   = (rem_sh >= {1'b0, cycles});
  assign rem_sub = CNT_W'(rem_sh - {1'b0, cycles});
  assign quo_nxt = {quo_q[Q_W-2:0], q_bit};

  always_comb begin
    state_d     = state_q;
    cyc_d       = cycles;
    ins_d       = instrs;
    evt_d       = evt_q;
    ovf_d       = overflow;
    ipc_d       = ipc;
    ipc_valid_d = ipc_valid;
    rem_d       = rem_q;
    quo_d       = quo_q;
    bit_cnt_d   = bit_cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          cyc_d       = '0;
          ins_d       = '0;
          for (int i = 0; i < NUM_EVT; i++) evt_d[i] = '0;
          ovf_d       = 1'b0;
          ipc_d       = '0;
          ipc_valid_d = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          cyc_d       = '0;
          ins_d       = '0;
          for (int i = 0; i < NUM_EVT; i++) evt_d[i] = '0;
          ovf_d       = 1'b0;
          ipc_d       = '0;
          ipc_valid_d = 1'b0;
        end else begin
          cyc_d = cyc_s[CNT_W-1:0];
          ins_d = ins_s[CNT_W-1:0];
          ovf_d = overflow | cyc_s[CNT_W] | ins_s[CNT_W];
          for (int i = 0; i < NUM_EVT; i++) begin
            evt_d[i] = evt_s[i][CNT_W-1:0];
            ovf_d    = ovf_d | evt_s[i][CNT_W];
          end
          // The stop cycle itself is counted, so the divider loads the updated totals.
          if (stop_edge) begin
            state_d   = DIV;
            rem_d     = '0;
            quo_d     = Q_W'(ins_d) << FRAC_W;
            bit_cnt_d = '0;
          end
        end
      end
      DIV: begin
        rem_d     = q_bit ? rem_sub : rem_sh[CNT_W-1:0];
        quo_d     = quo_nxt;
        bit_cnt_d = bit_cnt_q + QC_W'(1);
        if (bit_cnt_q == QC_W'(Q_W - 1)) begin
          state_d     = DONE;
          ipc_valid_d = 1'b1;
          if ((cycles == '0) || ((quo_nxt >> CNT_W) != '0)) ipc_d = '1;
          else                                                ipc_d = quo_nxt[CNT_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DIV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stat_prev_q <= 1'b0;
      cycles      <= '0;
      instrs      <= '0;
      for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= '0;
      ipc         <= '0;
      ipc_valid   <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      stat_prev_q <= stat_control;
      cycles      <= cyc_d;
      instrs      <= ins_d;
      evt_q       <= evt_d;
      ipc         <= ipc_d;
      ipc_valid   <= ipc_valid_d;
      busy        <= busy_d;
      overflow    <= ovf_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt
    assign evt_cnt[g*CNT_W +: CNT_W] = evt_q[g];
  end

`ifdef PERF_STATS_DISPLAY_EN
  // End-of-run report, printed once as the result is registered.
  always @(posedge clk) begin
    string line;
    longint unsigned frac;
    if (rst_n && state_q == DIV && state_d == DONE) begin
      frac = (64'(ipc_d[FRAC_W-1:0]) * 64'd1000) >> FRAC_W;
      line = $sformatf("%0t perf: cycles=%0d instrs=%0d ipc=%0d.%03d", $time, cycles, instrs,
                       ipc_d >> FRAC_W, frac);
      for (int i = 0; i < NUM_EVT; i++) line = {line, $sformatf(" evt%0d=%0d", i, evt_q[i])};
      if (overflow) line = {line, " OVERFLOW"};
      $display("%s", line);
    end
  end
`else
`endif

endmodule

// File: tb/tb_perf_stats_unit.sv
// Directed bench for perf_stats_unit: table of IPC runs plus reset, collision and saturation sequences.
module tb_perf_stats_unit;

  localparam int Q_A = 40;
  localparam int Q_B = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stat;
  logic [1:0]   instr_inc;
  logic [3:0]   evt;
  logic [31:0]  cycles, instrs, ipc;
  logic [127:0] evt_cnt;
  logic         ipc_valid, busy, overflow;

  logic         start_b, stat_b;
  logic [1:0]   inc_b;
  logic [0:0]   evt_b;
  logic [7:0]   cycles_b, instrs_b, ipc_b, evt_cnt_b;
  logic         ipc_valid_b, busy_b, overflow_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  perf_stats_unit u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stat_control(stat), .instr_inc(instr_inc),
    .evt(evt), .cycles(cycles), .instrs(instrs), .evt_cnt(evt_cnt), .ipc(ipc),
    .ipc_valid(ipc_valid), .busy(busy), .overflow(overflow)
  );

  perf_stats_unit #(.CNT_W(8), .NUM_EVT(1), .RET_W(2), .FRAC_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stat_control(stat_b), .instr_inc(inc_b),
    .evt(evt_b), .cycles(cycles_b), .instrs(instrs_b), .evt_cnt(evt_cnt_b), .ipc(ipc_b),
    .ipc_valid(ipc_valid_b), .busy(busy_b), .overflow(overflow_b)
  );

  typedef struct {
    int          n;
    int          inc;
    int          inc_cyc;
    logic [3:0]  emask;
    int          ecyc;
    logic [31:0] e_cyc;
    logic [31:0] e_ins;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic run_a(input int n, input int inc, input int inc_cyc, input logic [3:0] emask,
                       input int ecyc);
    @(negedge clk); start = 1'b1; stat = 1'b0; instr_inc = '0; evt = '0;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      instr_inc = (k <= inc_cyc) ? 2'(inc) : 2'd0;
      evt       = (k <= ecyc) ? emask : 4'd0;
      stat      = (k == n);
      @(negedge clk);
    end
    instr_inc = '0; evt = '0;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_cycles"}, 64'(cycles), 64'd0);
    chk({tag, "_instrs"}, 64'(instrs), 64'd0);
    chk({tag, "_evt"}, 64'(evt_cnt[63:0] | evt_cnt[127:64]), 64'd0);
    chk({tag, "_ipc"}, 64'(ipc), 64'd0);
    chk({tag, "_valid"}, 64'(ipc_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    vecs[0] = '{10, 2, 10, 4'b0000, 0, 32'd10, 32'd20, 32'h200};
    vecs[1] = '{3,  1, 1,  4'b0010, 2, 32'd3,  32'd1,  32'h55};
    vecs[2] = '{1,  3, 1,  4'b0001, 1, 32'd1,  32'd3,  32'h300};
    vecs[3] = '{7,  0, 0,  4'b0000, 0, 32'd7,  32'd0,  32'h0};
    vecs[4] = '{5,  3, 5,  4'b1111, 5, 32'd5,  32'd15, 32'h300};
    vecs[5] = '{4,  1, 3,  4'b1001, 1, 32'd4,  32'd3,  32'hC0};
    vecs[6] = '{9,  2, 4,  4'b0100, 9, 32'd9,  32'd8,  32'hE3};

    rst_n = 1'b0; start = 0; stat = 0; instr_inc = 0; evt = 0;
    start_b = 0; stat_b = 0; inc_b = 0; evt_b = 0;
    repeat (2) @(negedge clk);
    chk_zero_a("reset");
    rst_n = 1'b1;

    // Stop edge in IDLE must not start anything.
    instr_inc = 2'd1;
    @(negedge clk); stat = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_stop_busy", 64'(busy), 64'd0);
    chk("idle_stop_cycles", 64'(cycles), 64'd0);
    stat = 1'b0; instr_inc = '0;

    for (int v = 0; v < 7; v++) begin
      run_a(vecs[v].n, vecs[v].inc, vecs[v].inc_cyc, vecs[v].emask, vecs[v].ecyc);
      chk($sformatf("v%0d_busy_div", v), 64'(busy), 64'd1);
      chk($sformatf("v%0d_valid_early", v), 64'(ipc_valid), 64'd0);
      repeat (Q_A - 1) @(negedge clk);
      chk($sformatf("v%0d_valid_q-1", v), 64'(ipc_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", v), 64'(ipc_valid), 64'd1);
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
      chk($sformatf("v%0d_cycles", v), 64'(cycles), 64'(vecs[v].e_cyc));
      chk($sformatf("v%0d_instrs", v), 64'(instrs), 64'(vecs[v].e_ins));
      chk($sformatf("v%0d_ipc", v), 64'(ipc), 64'(vecs[v].e_ipc));
      chk($sformatf("v%0d_ovf", v), 64'(overflow), 64'd0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("v%0d_evt%0d", v, i), 64'(evt_cnt[i*32 +: 32]),
            vecs[v].emask[i] ? 64'(vecs[v].ecyc) : 64'd0);
      stat = 1'b0;
    end

    // Start and stop edge together in RUN: start wins, counters clear, still RUN.
    @(negedge clk); start = 1'b1; stat = 1'b0;
    @(negedge clk); start = 1'b0; instr_inc = 2'd1;
    repeat (3) @(negedge clk);
    start = 1'b1; stat = 1'b1;
    @(negedge clk);
    chk("coll_cycles", 64'(cycles), 64'd0);
    chk("coll_instrs", 64'(instrs), 64'd0);
    chk("coll_busy", 64'(busy), 64'd1);
    start = 1'b0; stat = 1'b0;
    @(negedge clk); stat = 1'b1;
    @(negedge clk); instr_inc = '0;
    chk("coll_stop_cycles", 64'(cycles), 64'd2);
    // start and a fresh stop edge during DIV are ignored.
    start = 1'b1; stat = 1'b0;
    @(negedge clk); start = 1'b0; stat = 1'b1;
    @(negedge clk);
    repeat (Q_A - 3) @(negedge clk);
    chk("div_ign_valid_early", 64'(ipc_valid), 64'd0);
    chk("div_ign_cycles", 64'(cycles), 64'd2);
    @(negedge clk);
    chk("div_ign_valid", 64'(ipc_valid), 64'd1);
    chk("div_ign_ipc", 64'(ipc), 64'h100);
    // Stop edge in DONE changes nothing.
    stat = 1'b0;
    @(negedge clk); stat = 1'b1;
    repeat (2) @(negedge clk);
    chk("done_stop_valid", 64'(ipc_valid), 64'd1);
    chk("done_stop_busy", 64'(busy), 64'd0);
    chk("done_stop_cycles", 64'(cycles), 64'd2);
    chk("done_stop_ipc", 64'(ipc), 64'h100);
    stat = 1'b0;

    // Reset mid-DIV clears everything immediately; counting needs a new start.
    run_a(10, 2, 10, 4'b0011, 4);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_a("rst_div");
    @(negedge clk); rst_n = 1'b1; stat = 1'b0; instr_inc = 2'd3;
    repeat (4) @(negedge clk);
    chk("post_rst_cycles", 64'(cycles), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    instr_inc = '0;
    run_a(2, 1, 2, 4'b0000, 0);
    repeat (Q_A) @(negedge clk);
    chk("post_rst_run_cycles", 64'(cycles), 64'd2);
    chk("post_rst_run_ipc", 64'(ipc), 64'h100);
    stat = 1'b0;

    // 8-bit instance: counters saturate, overflow sets, IPC quotient clamps.
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0; inc_b = 2'd3; evt_b = 1'b1;
    repeat (299) @(negedge clk);
    stat_b = 1'b1;
    @(negedge clk); inc_b = '0; evt_b = '0;
    chk("sat_cycles", 64'(cycles_b), 64'd255);
    chk("sat_instrs", 64'(instrs_b), 64'd255);
    chk("sat_evt", 64'(evt_cnt_b), 64'd255);
    chk("sat_ovf", 64'(overflow_b), 64'd1);
    chk("sat_busy", 64'(busy_b), 64'd1);
    repeat (Q_B - 1) @(negedge clk);
    chk("sat_valid_early", 64'(ipc_valid_b), 64'd0);
    @(negedge clk);
    chk("sat_valid", 64'(ipc_valid_b), 64'd1);
    chk("sat_ipc", 64'(ipc_b), 64'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
